// File: rtl/delay_line.sv
// delay_line -- runtime-configurable alignment delay.
//
// A WIDTH-bit sample is shifted through MAX_DEPTH physical register stages.
// Each stage also carries a valid bit. The output tap is chosen by a depth
// register D in the range 1..MAX_DEPTH. The chain always shifts at full
// length, so changing D simply moves the tap over the history already held.
//
// Ports:
//   clk       in   1      sole clock, posedge
//   reset     in   1      asynchronous, active-high
//   en        in   1      advance enable; the chain shifts only when en=1
//   signal    in   WIDTH  sample written into stage 0 on an enabled edge
//   flush     in   1      synchronous clear of data and valid stages (beats en)
//   depth_ld  in   1      load clamp(depth_in) into the depth register
//   depth_in  in   DW     requested depth
//   depth     out  DW     current depth register value D
//   q         out  WIDTH  stage[D-1]
//   q_valid   out  1      valid bit of stage[D-1]
module delay_line #(
  parameter int              WIDTH      = 4,
  parameter int              MAX_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              DEPTH_INIT = 1,
  localparam int             DW         = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] signal,
  input  logic             flush,
  input  logic             depth_ld,
  input  logic [DW-1:0]    depth_in,
  output logic [DW-1:0]    depth,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // A requested depth of 0 would select no stage, and anything past
  // MAX_DEPTH has no physical stage; both are pulled into range.
  function automatic logic [DW-1:0] clamp_depth(input logic [DW-1:0] v);
    if (v == '0)
      return DW'(1);
    else if (v > DW'(MAX_DEPTH))
      return DW'(MAX_DEPTH);
    else
      return v;
  endfunction

  logic [WIDTH-1:0]     r_stage [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] r_vld;
  logic [DW-1:0]        r_depth;
  logic [DW-1:0]        w_sel;

  // Data, valid and depth all return to their defined values on reset:
  // the reset value is visible on q, so the data stages are cleared too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
      r_vld   <= '0;
      r_depth <= DW'(DEPTH_INIT);
    end else begin
      // Depth load is independent of the stage update so that it composes
      // with a shift or a flush on the same edge.
      if (depth_ld) begin
        r_depth <= clamp_depth(depth_in);
      end

      if (flush) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          r_stage[i] <= RESET_VAL;
        end
        r_vld <= '0;
      end else if (en) begin
        r_stage[0] <= signal;
        r_vld[0]   <= 1'b1;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          r_stage[i] <= r_stage[i-1];
          r_vld[i]   <= r_vld[i-1];
        end
      end
    end
  end

  // Output tap: stage[D-1]. D is registered, so q only moves after an edge.
  assign w_sel = r_depth - DW'(1);

  always_comb begin
    q       = RESET_VAL;
    q_valid = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (w_sel == DW'(i)) begin
        q       = r_stage[i];
        q_valid = r_vld[i];
      end
    end
  end

  assign depth = r_depth;

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line with WIDTH=4, MAX_DEPTH=8, RESET_VAL=4'hA, DEPTH_INIT=3.
// A table of per-edge stimulus records with expected outputs is replayed,
// followed by a hand-written mid-cycle reset sequence.
module tb_delay_line;

  localparam int WIDTH     = 4;
  localparam int MAX_DEPTH = 8;
  localparam int DW        = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] signal;
  logic             flush;
  logic             depth_ld;
  logic [DW-1:0]    depth_in;
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  int n_vec;
  int n_err;

  delay_line #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .RESET_VAL (4'hA),
    .DEPTH_INIT(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .signal  (signal),
    .flush   (flush),
    .depth_ld(depth_ld),
    .depth_in(depth_in),
    .depth   (depth),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       flush;
    logic       ld;
    logic [3:0] din;
    logic [3:0] sig;
    logic [3:0] exp_q;
    logic       exp_v;
    logic [3:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic f, input logic l,
                              input logic [3:0] di, input logic [3:0] s,
                              input logic [3:0] eq, input logic ev,
                              input logic [3:0] ed);
    vec_t v;
    v.en = e; v.flush = f; v.ld = l; v.din = di; v.sig = s;
    v.exp_q = eq; v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  task automatic check_outs(input string name, input logic [3:0] eq,
                            input logic ev, input logic [3:0] ed);
    n_vec++;
    if (q !== eq || q_valid !== ev || depth !== ed) begin
      n_err++;
      $display("FAIL %s: got q=%h q_valid=%b depth=%0d, expected q=%h q_valid=%b depth=%0d",
               name, q, q_valid, depth, eq, ev, ed);
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic l,
                       input logic [3:0] di, input logic [3:0] s);
    en = e; flush = f; depth_ld = l; depth_in = di; signal = s;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    //            en fl ld din sig    q    v  d
    // basic delay at D=3
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h1, 4'hA, 0, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h2, 4'hA, 0, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h3, 4'h1, 1, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h4, 4'h2, 1, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h5, 4'h3, 1, 4'd3));
    // flush, then enable gating 5,x,6,x,7
    vecs.push_back(mk(1, 1, 0, 4'd0, 4'hF, 4'hA, 0, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h5, 4'hA, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 4'd0, 4'hE, 4'hA, 0, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h6, 4'hA, 0, 4'd3));
    vecs.push_back(mk(0, 0, 0, 4'd0, 4'hE, 4'hA, 0, 4'd3));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h7, 4'h5, 1, 4'd3));
    vecs.push_back(mk(0, 0, 0, 4'd0, 4'h1, 4'h5, 1, 4'd3));
    // go to D=4 (stage 3 not yet valid), fill, then flush with en and signal=9
    vecs.push_back(mk(0, 0, 1, 4'd4, 4'h0, 4'hA, 0, 4'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h8, 4'h5, 1, 4'd4));
    vecs.push_back(mk(1, 1, 0, 4'd0, 4'h9, 4'hA, 0, 4'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h1, 4'hA, 0, 4'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h2, 4'hA, 0, 4'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h3, 4'hA, 0, 4'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h4, 4'h1, 1, 4'd4));
    // D=2 with shift, then reload to 5, clamp 0 and 15
    vecs.push_back(mk(1, 0, 1, 4'd2, 4'h5, 4'h4, 1, 4'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h6, 4'h5, 1, 4'd2));
    vecs.push_back(mk(0, 0, 1, 4'd5, 4'h0, 4'h2, 1, 4'd5));
    vecs.push_back(mk(0, 0, 1, 4'd0, 4'h0, 4'h6, 1, 4'd1));
    vecs.push_back(mk(0, 0, 1, 4'd15, 4'h0, 4'hA, 0, 4'd8));
    // flush + 2 edges, then depth 5 exposes an invalid stage
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'h0, 4'hA, 0, 4'd8));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'hC, 4'hA, 0, 4'd8));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'hD, 4'hA, 0, 4'd8));
    vecs.push_back(mk(0, 0, 1, 4'd5, 4'h0, 4'hA, 0, 4'd5));
    // depth_ld with flush, then depth 2->4 on a shifting edge
    vecs.push_back(mk(0, 1, 1, 4'd2, 4'h0, 4'hA, 0, 4'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h1, 4'hA, 0, 4'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h2, 4'h1, 1, 4'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h3, 4'h2, 1, 4'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'h4, 4'h3, 1, 4'd2));
    vecs.push_back(mk(1, 0, 1, 4'd4, 4'h5, 4'h2, 1, 4'd4));

    // Reset state from power-up.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_initial", 4'hA, 1'b0, 4'd3);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].flush, vecs[i].ld, vecs[i].din, vecs[i].sig);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_v, vecs[i].exp_d);
    end

    // Mid-cycle asynchronous reset: outputs change with no clock edge.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("reset_async", 4'hA, 1'b0, 4'd3);

    // Reset dominates en, flush and depth_ld across an edge.
    drive(1'b1, 1'b0, 1'b1, 4'd6, 4'h7);
    @(posedge clk);
    #1;
    check_outs("reset_hold", 4'hA, 1'b0, 4'd3);

    // Refill at D=3 after reset release.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'h7);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'h8);
    @(posedge clk);
    #1;
    check_outs("refill_edge2", 4'hA, 1'b0, 4'd3);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'h9);
    @(posedge clk);
    #1;
    check_outs("refill_edge3", 4'h7, 1'b1, 4'd3);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    @(posedge clk);
    #1;
    check_outs("refill_hold", 4'h7, 1'b1, 4'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
